gamepad_input_decoder: RTL
==========================

Name: gamepad_input_decoder

Overview:
- Drives an SNES-compatible serial gamepad by generating the latch and clock signals, then shifts in the 16 button bits.
- Maps those bits to the five game actions and produces the 10-bit press/release event word that the player logic consumes on `input_data`.
- Sits between the top-level pad pins and the player/game-state logic; one instance per controller.

Parameters:
- CLK_DIV, 150: system clocks per pad tick (half pad-clock period; 6 us at 25 MHz); must be >= 4.
- POLL_PERIOD, 416667: system clocks from one poll start to the next (~60 Hz at 25 MHz); must exceed 34*CLK_DIV+2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pad_data  input  1  serial data from pad, active-low (0 = pressed), asynchronous to clk
- pad_latch  output  1  pad latch strobe, active-high
- pad_clk  output  1  pad shift clock, idles high
- input_data  output  10  [9:5] pressed events, [4:0] released events; bit order within each field {attack,right,left,down,up}
- buttons_held  output  5  current debounced-by-poll state, same bit order
- data_valid  output  1  one-cycle pulse per completed poll

Behaviour:
- Reset (async, immediate): state IDLE; pad_latch=0; pad_clk=1; input_data=0; buttons_held=0; data_valid=0; poll, tick and bit counters=0; shift register=0.
- pad_data is passed through a 2-flop synchronizer before use; both flops reset to 1 (released).
- Tick: a divider counts 0..CLK_DIV-1 and the tick fires at CLK_DIV-1. The divider is cleared on entry to LATCH.
- Poll counter: free-runs 0..POLL_PERIOD-1. The first poll starts at count POLL_PERIOD-1, i.e. POLL_PERIOD cycles after reset deasserts.
- IDLE:
  - pad_latch=0, pad_clk=1.
  - On poll start, go to LATCH.
- LATCH:
  - pad_latch=1, pad_clk=1 for exactly 2 ticks (2*CLK_DIV cycles), then go to SHIFT with bit index k=0.
- SHIFT, per bit k=0..15:
  - High phase: pad_clk=1, pad_latch=0 for 1 tick. The synchronized pad_data is sampled into shift bit k on the tick ending this phase.
  - Low phase: pad_clk=0 for 1 tick. The rising edge at its end advances the pad.
  - After the low phase of k=15, pad_clk returns to 1 and the block goes to UPDATE.
  - SHIFT lasts 32 ticks; a full poll lasts 34 ticks plus 1 cycle.
- Pad bit mapping (pressed = sampled 0):
  - 0=B, 4=Up, 5=Down, 6=Left, 7=Right, 8=A.
  - Bits 1-3 and 9-11 are ignored.
  - Bits 12-15 are signature bits and must read 1.
- Action mapping:
  - new[0]=Up, new[1]=Down, new[2]=Left, new[3]=Right, new[4]=A|B.
- Invalid frame: if any of bits 12-15 is sampled 0 (pad absent with pull-down, or faulty), then new=5'b00000.
- UPDATE (exactly 1 cycle), with outputs registered:
  - input_data[9:5] = new & ~buttons_held.
  - input_data[4:0] = ~new & buttons_held.
  - buttons_held <= new; data_valid <= 1.
  - Return to IDLE.
- Output timing:
  - input_data and data_valid are asserted for exactly the one cycle after UPDATE; otherwise input_data=0 and data_valid=0.
  - data_valid pulses every poll, even when nothing changed (input_data=0 in that case).
  - Press and release events on different actions in the same poll appear in the same word.
  - A press and a release of the same action within one poll are not observable and produce no event.
- The attack action is an OR of A and B:
  - Releasing one of A/B while the other is still held produces no release event.
  - The attack press event fires only on the 0->1 transition of A|B.
- Reset asserted mid-poll aborts the poll immediately with no partial update. pad_clk goes to 1 and pad_latch to 0 in the same instant.

Test Plan:
- CLK_DIV=4, POLL_PERIOD=200; release reset → pad_clk=1 and pad_latch=0 throughout; first pad_latch rise 200 cycles after release; latch high 8 cycles; 16 pad_clk low pulses of 4 cycles each; data_valid at cycle ~337 with input_data=0 and buttons_held=0 when the pad model returns all 1s.
- Pad model drives bit4 (Up)=0 → first poll: input_data=10'b00001_00000 and buttons_held=5'b00001 for one cycle with data_valid; second identical poll: input_data=0, data_valid=1.
- Up held, then the pad changes to Right pressed + Up released → single word input_data=10'b01000_00001, buttons_held=5'b01000.
- A pressed → 10'b10000_00000; then A+B held → 0; then B only → 0; then none → 10'b00000_10000.
- Up+Left held, then the pad drives all 16 bits 0 (invalid) → input_data=10'b00000_00101, buttons_held=0.
- Assert reset during SHIFT at bit 7 with pad_clk=0 → pad_clk=1, pad_latch=0 and outputs 0 immediately; after release, the next latch rise comes 200 cycles later and the first completed poll reports correct press events.

Source files
------------

// File: rtl/gamepad_input_decoder_if.sv
// Pad-side and player-side signals of one gamepad decoder.
//   pad_data     : serial pad data, active-low (0 = pressed)
//   pad_latch    : latch strobe to the pad, active-high
//   pad_clk      : shift clock to the pad, idles high
//   input_data   : [9:5] press events, [4:0] release events {attack,right,left,down,up}
//   buttons_held : current per-poll action state, same bit order
//   data_valid   : one-cycle pulse per completed poll
// master = decoder side, slave = pad/player side.
interface gamepad_input_decoder_if;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [9:0] input_data;
    logic [4:0] buttons_held;
    logic       data_valid;

    modport master (
        input  pad_data,
        output pad_latch, pad_clk, input_data, buttons_held, data_valid
    );

    modport slave (
        output pad_data,
        input  pad_latch, pad_clk, input_data, buttons_held, data_valid
    );
endinterface

// File: rtl/gamepad_input_decoder.sv
// SNES-compatible gamepad poller and action decoder.
// Every POLL_PERIOD cycles it latches the pad, clocks in 16 bits, maps them
// to {attack,right,left,down,up} and emits a registered press/release word.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : gamepad_input_decoder_if.master (pad pins + event outputs)
module gamepad_input_decoder #(
    parameter int CLK_DIV     = 150,
    parameter int POLL_PERIOD = 416667
) (
    input  logic clk,
    input  logic reset,
    gamepad_input_decoder_if.master bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    typedef enum logic [2:0] {IDLE, LATCH, SHIFT_HI, SHIFT_LO, UPDATE} state_t;

    state_t              state, next_state;
    logic [DIV_W-1:0]    div_cnt;
    logic [POLL_W-1:0]   poll_cnt;
    logic                lat_tick;     // which of the two latch ticks we are in
    logic [3:0]          bit_idx;
    logic [15:0]         shreg;
    logic [1:0]          sync;
    logic [9:0]          input_data_q;
    logic [4:0]          held_q;
    logic                valid_q;
    logic                tick, poll_start, enter_latch;
    logic                pad_latch_c, pad_clk_c;
    logic [15:0]         pressed;
    logic                frame_ok;
    logic [4:0]          new_btn;

    assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign poll_start  = (poll_cnt == POLL_W'(POLL_PERIOD - 1));
    assign enter_latch = (state == IDLE) && (next_state == LATCH);

    // Pad data is asynchronous; sync flops park at "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], bus.pad_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pad_latch_c = 1'b0;
        pad_clk_c   = 1'b1;
        case (state)
            IDLE:     if (poll_start) next_state = LATCH;
            LATCH: begin
                pad_latch_c = 1'b1;
                if (tick && lat_tick) next_state = SHIFT_HI;
            end
            SHIFT_HI: if (tick) next_state = SHIFT_LO;
            SHIFT_LO: begin
                pad_clk_c = 1'b0;
                if (tick) next_state = (bit_idx == 4'd15) ? UPDATE : SHIFT_HI;
            end
            UPDATE:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Timing counters and the bit shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
            div_cnt  <= '0;
            lat_tick <= 1'b0;
            bit_idx  <= 4'd0;
            shreg    <= 16'h0000;
        end else begin
            poll_cnt <= poll_start ? '0 : poll_cnt + 1'b1;
            // Divider restarts on latch entry so every phase is a full tick.
            if (enter_latch || tick) div_cnt <= '0;
            else                     div_cnt <= div_cnt + 1'b1;
            if (enter_latch) begin
                lat_tick <= 1'b0;
                bit_idx  <= 4'd0;
            end else begin
                if (state == LATCH && tick)    lat_tick <= ~lat_tick;
                if (state == SHIFT_LO && tick) bit_idx  <= bit_idx + 4'd1;
            end
            // Sample at the end of the high phase, well after the pad's
            // rising-edge update has passed through the synchronizer.
            if (state == SHIFT_HI && tick) shreg[bit_idx] <= sync[1];
        end
    end

    // Active-low pad bits; a missing or faulty pad fails the signature.
    assign pressed  = ~shreg;
    assign frame_ok = &shreg[15:12];
    assign new_btn  = frame_ok ? {pressed[8] | pressed[0], pressed[7], pressed[6],
                                  pressed[5], pressed[4]} : 5'b00000;

    // Select, Start, X, Y, L, R carry no action.
    logic unused_pad_bits;
    assign unused_pad_bits = ^{shreg[11:9], shreg[3:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            input_data_q <= 10'd0;
            held_q       <= 5'd0;
            valid_q      <= 1'b0;
        end else begin
            input_data_q <= 10'd0;
            valid_q      <= 1'b0;
            if (state == UPDATE) begin
                input_data_q <= {new_btn & ~held_q, ~new_btn & held_q};
                held_q       <= new_btn;
                valid_q      <= 1'b1;
            end
        end
    end

    assign bus.pad_latch    = pad_latch_c;
    assign bus.pad_clk      = pad_clk_c;
    assign bus.input_data   = input_data_q;
    assign bus.buttons_held = held_q;
    assign bus.data_valid   = valid_q;
endmodule
